display_scanner: RTL and testbench



---
 rtl/clock_pkg.sv | 25 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/display_scanner.sv | 107 ++++++++++
 tb/tb_display_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// digit-word field positions, blank pattern, glyph table and FSM states.
package clock_pkg;

  localparam int EN_BIT  = 5;
  localparam int VAL_MSB = 4;
  localparam int VAL_LSB = 1;
  localparam int DP_BIT  = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [5:0] digit_word_t;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module seg7_decoder
  import clock_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_n
);

  assign seg_n = GLYPH_TABLE[value];

endmodule

// File: rtl/display_scanner.sv
// Eight-digit time-multiplexed seven-segment scanner with per-digit blanking
// and a frame-aligned shadow snapshot of the digit inputs.
module display_scanner
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DIGIT_HZ     = 1_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_start
);

  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int CW    = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL) begin : g_bad_cfg
    $error("display_scanner: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DWELL");
  end

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  scan_state_e   state_reg, state_next;
  digit_word_t   shadow_reg [8];
  digit_word_t   digit_in [8];
  digit_word_t   sel_word;
  logic          snap;
  logic [6:0]    seg_dec;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign digit_in = '{d1, d2, d3, d4, d5, d6, d7, d8};
  assign snap     = (cnt_reg == '0) && (idx_reg == 3'd0);
  assign sel_word = shadow_reg[idx_reg];

  seg7_decoder u_decoder (
    .value (sel_word[VAL_MSB:VAL_LSB]),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      idx_reg     <= 3'd0;
      state_reg   <= ST_BLANK;
      an_n        <= 8'hFF;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
      for (int i = 0; i < 8; i++) shadow_reg[i] <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      state_reg   <= state_next;
      an_n        <= an_next;
      seg_n       <= seg_next;
      dp_n        <= dp_next;
      frame_start <= snap;
      if (snap) begin
        for (int i = 0; i < 8; i++) shadow_reg[i] <= digit_in[i];
      end
    end
  end

  always_comb begin
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    state_next = state_reg;
    an_next    = 8'hFF;
    seg_next   = SEG_BLANK;
    dp_next    = 1'b1;

    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = idx_reg + 3'd1;
    end

    case (state_reg)
      ST_BLANK: if (cnt_reg == CNT_BLANK_END) state_next = ST_DRIVE;
      ST_DRIVE: if (cnt_reg == CNT_LAST)      state_next = ST_BLANK;
      default:  state_next = ST_BLANK;
    endcase

    // Disabled digits keep their anode off but still present decoded segments.
    if (state_reg == ST_DRIVE) begin
      an_next[idx_reg] = ~sel_word[EN_BIT];
      seg_next         = seg_dec;
      dp_next          = sel_word[DP_BIT];
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner at DWELL=10, BLANK_CYCLES=2; cycle n is
// the interval after the n-th rising edge following reset release.
module tb_display_scanner;

  localparam int CLK_HZ       = 100;
  localparam int DIGIT_HZ     = 10;
  localparam int BLANK_CYCLES = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] d [8];
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [6:0] glyph [16];
  logic [7:0] one_hot;

  display_scanner #(
    .CLK_HZ       (CLK_HZ),
    .DIGIT_HZ     (DIGIT_HZ),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .d1          (d[0]),
    .d2          (d[1]),
    .d3          (d[2]),
    .d4          (d[3]),
    .d5          (d[4]),
    .d6          (d[5]),
    .d7          (d[6]),
    .d8          (d[7]),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] mk(input bit en, input int v, input bit dp);
    return {en, 4'(v), dp};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cycle %0d got %h want %h", tag, cyc, got, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, with per-cycle invariants.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    chk("onehot", 8'($countones(~an_n) <= 1), 8'd1);
    chk("frame_start", 8'(frame_start), 8'((cyc % 80) == 1));
    if (((cyc - 1) % 10) < 2) chk("blank_an", an_n, 8'hFF);
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int k = 0; k < 8; k++) d[k] = mk(1'b1, k, 1'b1);

    repeat (2) @(negedge clock);
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", 8'(seg_n), 8'h7F);
    chk("rst_dp", 8'(dp_n), 8'h01);
    chk("rst_fs", 8'(frame_start), 8'h00);

    reset = 1'b1;
    cyc   = 0;
    chk("fs_c0", 8'(frame_start), 8'h00);

    // Frame 1: digit k+1 shows value k.
    for (int k = 0; k < 8; k++) begin
      one_hot = 8'h01 << k;
      goto(10 * k + 3);
      chk("scan_an_first", an_n, ~one_hot);
      chk("scan_seg", 8'(seg_n), 8'(glyph[k]));
      chk("scan_dp", 8'(dp_n), 8'h01);
      goto(10 * k + 10);
      chk("scan_an_last", an_n, ~one_hot);
      if (k == 6) begin
        d[0] = mk(1'b1, 3, 1'b1);
        d[2] = mk(1'b0, 5, 1'b1);
      end
      goto(10 * k + 11);
      chk("scan_an_gap", an_n, 8'hFF);
    end

    // Frame 2: d1 value 3, d3 disabled for its whole dwell.
    goto(83);
    chk("f2_d1_an", an_n, 8'hFE);
    chk("f2_d1_seg", 8'(seg_n), 8'(glyph[3]));
    for (int n = 101; n <= 110; n++) begin
      goto(n);
      chk("d3_off_an", an_n, 8'hFF);
      if (n == 105) chk("d3_off_seg", 8'(seg_n), 8'(glyph[5]));
    end
    d[2] = mk(1'b1, 2, 1'b1);

    // Mid-frame change of d1 must wait for the next snapshot.
    goto(125);
    d[0] = mk(1'b1, 9, 1'b1);
    goto(161);
    chk("f3_fs", 8'(frame_start), 8'h01);
    goto(163);
    chk("f3_d1_an", an_n, 8'hFE);
    chk("f3_d1_seg", 8'(seg_n), 8'(glyph[9]));

    // Glyph sweep on d1, decimal point lit for even values.
    for (int v = 0; v < 16; v++) begin
      goto(200 + 80 * v);
      d[0] = mk(1'b1, v, (v % 2) == 1);
      goto(243 + 80 * v);
      chk("sweep_an", an_n, 8'hFE);
      chk("sweep_seg", 8'(seg_n), 8'(glyph[v]));
      chk("sweep_dp", 8'(dp_n), 8'(v % 2));
    end

    // Reset at idx 5, cnt 6 blanks outputs immediately.
    goto(1576);
    chk("pre_rst_an", an_n, 8'hDF);
    chk("pre_rst_seg", 8'(seg_n), 8'(glyph[5]));
    reset = 1'b0;
    #1;
    chk("async_rst_an", an_n, 8'hFF);
    chk("async_rst_seg", 8'(seg_n), 8'h7F);
    chk("async_rst_dp", 8'(dp_n), 8'h01);
    chk("async_rst_fs", 8'(frame_start), 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cyc   = 0;
    step();
    chk("restart_fs", 8'(frame_start), 8'h01);
    goto(3);
    chk("restart_an", an_n, 8'hFE);
    chk("restart_seg", 8'(seg_n), 8'(glyph[15]));
    chk("restart_dp", 8'(dp_n), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
